aes_round_ctrl: RTL

//  Sequencing FSM for the iterative AES datapath inside aes_core.

---
 rtl/aes_round_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencing FSM for the iterative AES round datapath.
//
// Accepts one block per in_valid_i/in_ready_o handshake, resolves the key
// length, optionally runs a full forward key expansion (decryption), then
// steps the state register through the initial AddRoundKey, Nr-1 full rounds
// and the final round. The result is held with out_valid_o until the consumer
// takes it with out_ready_i.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   clear_i               synchronous abort back to IDLE
//   in_valid_i/in_ready_o input handshake; mode_i, key_len_i sampled at accept
//   key_len_o             latched, resolved key length (one-hot)
//   key_load_o            load key register (accept cycle)
//   key_step_o/key_dir_o  advance key schedule, 0 forward / 1 reverse
//   state_we_o            write state register
//   state_sel_o           0 hold, 1 input^key, 2 full round, 3 final round
//   round_o               current round index
//   out_valid_o/out_ready_i output handshake
//   busy_o                FSM not IDLE
module aes_round_ctrl #(
    parameter bit AES192Enable = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic       mode_i,
    input  logic [2:0] key_len_i,
    output logic [2:0] key_len_o,
    output logic       key_load_o,
    output logic       key_step_o,
    output logic       key_dir_o,
    output logic       state_we_o,
    output logic [1:0] state_sel_o,
    output logic [3:0] round_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StKeygen = 3'd1,
        StInit   = 3'd2,
        StRound  = 3'd3,
        StFinal  = 3'd4,
        StOut    = 3'd5
    } state_e;

    state_e     state_q;
    logic [3:0] round_q;
    logic       mode_q;
    logic [2:0] key_len_q;

    logic [2:0] key_len_res;
    logic [3:0] nr;
    logic       accept;

    // Anything that is not a legal one-hot (or 192 when disabled) means 128.
    always_comb begin
        key_len_res = 3'b001;
        case (key_len_i)
            3'b010:  key_len_res = AES192Enable ? 3'b010 : 3'b001;
            3'b100:  key_len_res = 3'b100;
            default: key_len_res = 3'b001;
        endcase
    end

    // key_len_q is always one of the three legal one-hot values.
    always_comb begin
        case (key_len_q)
            3'b100:  nr = 4'd14;
            3'b010:  nr = 4'd12;
            default: nr = 4'd10;
        endcase
    end

    // rst_i gates in_ready_o so nothing is offered while reset is held.
    assign in_ready_o = (state_q == StIdle) & ~clear_i & ~rst_i;
    assign accept     = in_ready_o & in_valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            round_q   <= 4'd0;
            mode_q    <= 1'b0;
            key_len_q <= 3'b001;
        end else if (clear_i) begin
            state_q <= StIdle;
            round_q <= 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        mode_q    <= mode_i;
                        key_len_q <= key_len_res;
                        if (mode_i) begin
                            state_q <= StKeygen;
                            round_q <= 4'd1;
                        end else begin
                            state_q <= StInit;
                            round_q <= 4'd0;
                        end
                    end
                end
                StKeygen: begin
                    if (round_q >= nr) begin
                        state_q <= StInit;
                        round_q <= 4'd0;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                StInit: begin
                    state_q <= StRound;
                    round_q <= 4'd1;
                end
                StRound: begin
                    if (round_q >= nr - 4'd1) begin
                        state_q <= StFinal;
                        round_q <= nr;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                StFinal: begin
                    state_q <= StOut;
                    round_q <= 4'd0;
                end
                StOut: begin
                    if (out_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    round_q <= 4'd0;
                end
            endcase
        end
    end

    // Datapath strobes decode from the registered state; clear_i squashes
    // them in the same cycle so an aborted operation never writes.
    always_comb begin
        key_step_o  = 1'b0;
        key_dir_o   = 1'b0;
        state_we_o  = 1'b0;
        state_sel_o = 2'd0;
        out_valid_o = 1'b0;
        if (!clear_i) begin
            case (state_q)
                StKeygen: begin
                    key_step_o = 1'b1;
                end
                StInit: begin
                    state_we_o  = 1'b1;
                    state_sel_o = 2'd1;
                end
                StRound: begin
                    state_we_o  = 1'b1;
                    state_sel_o = 2'd2;
                    key_step_o  = 1'b1;
                    key_dir_o   = mode_q;
                end
                StFinal: begin
                    state_we_o  = 1'b1;
                    state_sel_o = 2'd3;
                    key_step_o  = 1'b1;
                    key_dir_o   = mode_q;
                end
                StOut: begin
                    out_valid_o = 1'b1;
                end
                default: begin
                    out_valid_o = 1'b0;
                end
            endcase
        end
    end

    assign key_load_o = accept;
    assign round_o    = round_q;
    assign key_len_o  = key_len_q;
    assign busy_o     = (state_q != StIdle);

endmodule
